// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch slice.
//   state_t  : control FSM states (idle / run / pause)
//   DIGIT_W  : width of one BCD digit
//   DEC_MAX  : highest value of a plain decimal digit
package stopwatch_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned DEC_MAX = 9;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2
    } state_t;

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One BCD counter digit with synchronous clear and rollover at MAX.
//   mclk   : system clock
//   rst_n  : asynchronous active-low reset
//   clr    : synchronous clear to 0 (wins over en)
//   en     : advance by one this cycle
//   q      : current digit value
//   carry  : en while the digit sits at MAX (enables the next digit up)
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX = 9
) (
    input  logic               mclk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    localparam logic [DIGIT_W-1:0] MaxQ = DIGIT_W'(MAX);

    logic [DIGIT_W-1:0] q_q;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (clr) begin
            q_q <= '0;
        end else if (en) begin
            q_q <= (q_q == MaxQ) ? '0 : q_q + DIGIT_W'(1);
        end
    end

    assign q     = q_q;
    assign carry = en & (q_q == MaxQ);

endmodule

// File: rtl/stopwatch_core.sv
// Tenths-of-a-second stopwatch, m:ss.t in BCD, all logic on mclk.
//   mclk      : system clock (only clock)
//   rst_n     : asynchronous active-low reset
//   slow_clk  : ~10 Hz divided clock, mclk-synchronous; sampled as a tick enable
//   btn_start : start/pause button level (asynchronous, debounced)
//   btn_clear : clear button level (asynchronous, debounced)
//   bcd       : {min, sec_tens, sec_units, tenths}
//   running   : registered, high while in the run state
//   wrap      : registered one-cycle pulse after 9:59.9 -> 0:00.0
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned MIN_MAX  = 9,
    parameter int unsigned SECT_MAX = 5
) (
    input  logic        mclk,
    input  logic        rst_n,
    input  logic        slow_clk,
    input  logic        btn_start,
    input  logic        btn_clear,
    output logic [15:0] bcd,
    output logic        running,
    output logic        wrap
);

    logic   slow_q;
    logic   start_s1_q, start_s2_q, start_prev_q;
    logic   clear_s1_q, clear_s2_q, clear_prev_q;
    state_t state_q;
    logic   running_q;
    logic   wrap_q;

    logic tick;
    logic start_p;
    logic clear_p;
    logic tenths_en;

    logic [DIGIT_W-1:0] tenths_q, sec_u_q, sec_t_q, min_q;
    logic               tenths_c, sec_u_c, sec_t_c, min_c;

    // Edge detect on the slow clock and 2-FF sync + edge detect on each button.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            slow_q       <= 1'b0;
            start_s1_q   <= 1'b0;
            start_s2_q   <= 1'b0;
            start_prev_q <= 1'b0;
            clear_s1_q   <= 1'b0;
            clear_s2_q   <= 1'b0;
            clear_prev_q <= 1'b0;
        end else begin
            slow_q       <= slow_clk;
            start_s1_q   <= btn_start;
            start_s2_q   <= start_s1_q;
            start_prev_q <= start_s2_q;
            clear_s1_q   <= btn_clear;
            clear_s2_q   <= clear_s1_q;
            clear_prev_q <= clear_s2_q;
        end
    end

    assign tick    = slow_clk & ~slow_q;
    assign start_p = start_s2_q & ~start_prev_q;
    assign clear_p = clear_s2_q & ~clear_prev_q;

    // The tick is judged against the current (pre-transition) state.
    assign tenths_en = (state_q == StRun) & tick;

    // Control FSM with registered outputs; clear dominates everything.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            wrap_q <= min_c & ~clear_p;
            if (clear_p) begin
                state_q   <= StIdle;
                running_q <= 1'b0;
            end else if (start_p) begin
                unique case (state_q)
                    StIdle:  begin state_q <= StRun;   running_q <= 1'b1; end
                    StRun:   begin state_q <= StPause; running_q <= 1'b0; end
                    StPause: begin state_q <= StRun;   running_q <= 1'b1; end
                    default: begin state_q <= StIdle;  running_q <= 1'b0; end
                endcase
            end
        end
    end

    bcd_digit #(.MAX(DEC_MAX)) u_tenths (
        .mclk  (mclk),
        .rst_n (rst_n),
        .clr   (clear_p),
        .en    (tenths_en),
        .q     (tenths_q),
        .carry (tenths_c)
    );

    bcd_digit #(.MAX(DEC_MAX)) u_sec_units (
        .mclk  (mclk),
        .rst_n (rst_n),
        .clr   (clear_p),
        .en    (tenths_c),
        .q     (sec_u_q),
        .carry (sec_u_c)
    );

    bcd_digit #(.MAX(SECT_MAX)) u_sec_tens (
        .mclk  (mclk),
        .rst_n (rst_n),
        .clr   (clear_p),
        .en    (sec_u_c),
        .q     (sec_t_q),
        .carry (sec_t_c)
    );

    // Carry out of the minutes digit marks the full 9:59.9 rollover.
    bcd_digit #(.MAX(MIN_MAX)) u_min (
        .mclk  (mclk),
        .rst_n (rst_n),
        .clr   (clear_p),
        .en    (sec_t_c),
        .q     (min_q),
        .carry (min_c)
    );

    assign bcd     = {min_q, sec_t_q, sec_u_q, tenths_q};
    assign running = running_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;

    localparam int MIN_MAX  = 9;
    localparam int SECT_MAX = 5;
    localparam int PER_MIN  = 100 * (SECT_MAX + 1);
    localparam int TOTAL    = (MIN_MAX + 1) * PER_MIN;

    logic        mclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        slow_clk = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_clear = 1'b0;
    logic [15:0] bcd;
    logic        running;
    logic        wrap;

    stopwatch_core #(
        .MIN_MAX  (MIN_MAX),
        .SECT_MAX (SECT_MAX)
    ) dut (
        .mclk      (mclk),
        .rst_n     (rst_n),
        .slow_clk  (slow_clk),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .bcd       (bcd),
        .running   (running),
        .wrap      (wrap)
    );

    always #10 mclk = ~mclk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: elapsed time kept as a plain count of tenths.
    int       m_count;
    int       m_state;      // 0 idle, 1 run, 2 pause
    bit       m_wrap;
    bit       m_slow_prev;
    bit [2:0] m_hs, m_hc;   // button levels seen at the last three edges, [0] newest

    function automatic logic [15:0] to_bcd(input int c);
        logic [3:0] d3, d2, d1, d0;
        d3 = 4'(c / PER_MIN);
        d2 = 4'((c / 100) % (SECT_MAX + 1));
        d1 = 4'((c / 10) % 10);
        d0 = 4'(c % 10);
        return {d3, d2, d1, d0};
    endfunction

    task automatic model_reset();
        m_count     = 0;
        m_state     = 0;
        m_wrap      = 1'b0;
        m_slow_prev = 1'b0;
        m_hs        = '0;
        m_hc        = '0;
    endtask

    task automatic model_edge();
        bit sp, cp, tk;
        if (!rst_n) begin
            model_reset();
            return;
        end
        sp = m_hs[1] & ~m_hs[2];
        cp = m_hc[1] & ~m_hc[2];
        tk = slow_clk & ~m_slow_prev;
        m_wrap = 1'b0;
        if (cp) begin
            m_count = 0;
            m_state = 0;
        end else begin
            if (m_state == 1 && tk) begin
                if (m_count == TOTAL - 1) begin
                    m_count = 0;
                    m_wrap  = 1'b1;
                end else begin
                    m_count++;
                end
            end
            if (sp) m_state = (m_state == 1) ? 2 : 1;
        end
        m_slow_prev = slow_clk;
        m_hs = {m_hs[1:0], btn_start};
        m_hc = {m_hc[1:0], btn_clear};
    endtask

    int wrap_seen = 0;
    int run_rises = 0;
    bit prev_run  = 1'b0;

    // One mclk cycle: model advances on the edge, DUT checked on the falling edge.
    task automatic step();
        @(posedge mclk);
        model_edge();
        @(negedge mclk);
        check_eq("bcd", 32'(bcd), 32'(to_bcd(m_count)));
        check_eq("running", 32'(running), 32'(m_state == 1));
        check_eq("wrap", 32'(wrap), 32'(m_wrap));
        if (wrap) wrap_seen++;
        if (running && !prev_run) run_rises++;
        prev_run = running;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            slow_clk = 1'b1;
            step();
            slow_clk = 1'b0;
            step();
        end
    endtask

    task automatic press_start();
        slow_clk  = 1'b0;
        btn_start = 1'b1;
        steps(3);
        btn_start = 1'b0;
        steps(3);
    endtask

    task automatic press_clear();
        slow_clk  = 1'b0;
        btn_clear = 1'b1;
        steps(3);
        btn_clear = 1'b0;
        steps(3);
    endtask

    int slow_left;
    int start_hold;
    int clear_hold;

    initial begin
        model_reset();

        // Reset state, observed while reset is held.
        steps(3);
        check_eq("rst_bcd", 32'(bcd), 32'h0);
        check_eq("rst_running", 32'(running), 32'h0);
        check_eq("rst_wrap", 32'(wrap), 32'h0);
        rst_n = 1'b1;
        steps(2);

        // Ticks in idle do nothing.
        ticks(10);
        check_eq("idle_ticks_bcd", 32'(bcd), 32'h0);
        check_eq("idle_ticks_running", 32'(running), 32'h0);

        // Start, 15 ticks, pause, 5 more ticks.
        press_start();
        ticks(15);
        check_eq("run15_bcd", 32'(bcd), 32'h0015);
        check_eq("run15_running", 32'(running), 32'h1);
        press_start();
        ticks(5);
        check_eq("pause_bcd", 32'(bcd), 32'h0015);
        check_eq("pause_running", 32'(running), 32'h0);

        // Carry chain 0:59.9 -> 1:00.0, then on to the 9:59.9 rollover.
        press_clear();
        check_eq("clear_bcd", 32'(bcd), 32'h0);
        press_start();
        ticks(599);
        check_eq("pre_carry_bcd", 32'(bcd), 32'h0599);
        ticks(1);
        check_eq("carry_bcd", 32'(bcd), 32'h1000);
        ticks(TOTAL - 2 - 600);
        check_eq("pre_wrap_bcd", 32'(bcd), 32'h9598);
        wrap_seen = 0;
        ticks(1);
        check_eq("last_bcd", 32'(bcd), 32'h9599);
        ticks(1);
        check_eq("wrap_bcd", 32'(bcd), 32'h0000);
        check_eq("wrap_once", 32'(wrap_seen), 32'd1);
        check_eq("wrap_running", 32'(running), 32'h1);

        // Clear and tick in the same cycle at 0:04.2: clear wins.
        ticks(42);
        check_eq("pre_clr_bcd", 32'(bcd), 32'h0042);
        btn_clear = 1'b1;
        steps(2);
        slow_clk = 1'b1;
        step();
        check_eq("clr_tick_bcd", 32'(bcd), 32'h0);
        check_eq("clr_tick_running", 32'(running), 32'h0);
        btn_clear = 1'b0;
        slow_clk  = 1'b0;
        steps(3);

        // Asynchronous reset mid-count at 0:30.7.
        press_start();
        ticks(307);
        check_eq("pre_rst_bcd", 32'(bcd), 32'h0307);
        #3 rst_n = 1'b0;
        #1;
        check_eq("async_rst_bcd", 32'(bcd), 32'h0);
        check_eq("async_rst_running", 32'(running), 32'h0);
        model_reset();
        step();
        rst_n = 1'b1;
        steps(2);

        // Holding start for 100 cycles gives exactly one entry into run.
        run_rises = 0;
        btn_start = 1'b1;
        steps(100);
        btn_start = 1'b0;
        steps(4);
        check_eq("hold_one_run", 32'(run_rises), 32'd1);
        check_eq("hold_running", 32'(running), 32'h1);

        // Randomized traffic against the model.
        slow_left  = 1;
        start_hold = 0;
        clear_hold = 0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            slow_left--;
            if (slow_left == 0) begin
                slow_clk  = ~slow_clk;
                slow_left = $urandom_range(1, 3);
            end
            if (start_hold > 0) begin
                btn_start = 1'b1;
                start_hold--;
            end else begin
                btn_start = 1'b0;
                if ($urandom_range(0, 39) == 0) start_hold = $urandom_range(1, 12);
            end
            if (clear_hold > 0) begin
                btn_clear = 1'b1;
                clear_hold--;
            end else begin
                btn_clear = 1'b0;
                if ($urandom_range(0, 2499) == 0) clear_hold = $urandom_range(1, 5);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
